// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one result bit per clock, LSB first.
// Operands latch on START in IDLE and SUM/COUT/OVF publish together on entry to FIN.
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             CLOCK_50,
    input  logic             RESET_N,
    input  logic             START,
    input  logic             SUB,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT,
    output logic             OVF
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic             cmsb;
    logic [CW-1:0]    cnt;
    logic             s;
    logic             cnext;

    always_comb begin
        s     = x[0] ^ y[0] ^ carry;
        cnext = (x[0] & y[0]) | (x[0] & carry) | (y[0] & carry);
    end

    assign BUSY = (state == RUN) || (state == FIN);
    assign DONE = (state == FIN);

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            state <= IDLE;
            x     <= '0;
            y     <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cmsb  <= 1'b0;
            cnt   <= '0;
            SUM   <= '0;
            COUT  <= 1'b0;
            OVF   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (START) begin
                        x     <= A;
                        y     <= SUB ? ~B : B;
                        carry <= SUB ? 1'b1 : CIN;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc   <= {s, acc[WIDTH-1:1]};
                    x     <= x >> 1;
                    y     <= y >> 1;
                    carry <= cnext;
                    if (cnt == LAST) begin
                        // Last bit: publish from the combinational next values so FIN sees the full result.
                        cmsb  <= carry;
                        SUM   <= {s, acc[WIDTH-1:1]};
                        COUT  <= cnext;
                        OVF   <= carry ^ cnext;
                        state <= FIN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: directed cases, randomized operations
// against an arithmetic reference model, reset abort, and a WIDTH=4 build.
module tb_serial_addsub;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start8, sub8, cin8;
    logic [7:0] a8, b8;
    logic       busy8, done8, cout8, ovf8;
    logic [7:0] sum8;
    logic       start4, sub4, cin4;
    logic [3:0] a4, b4;
    logic       busy4, done4, cout4, ovf4;
    logic [3:0] sum4;

    int total = 0;
    int bad   = 0;
    logic [7:0] last8;

    always #5 clk = ~clk;

    serial_addsub #(.WIDTH(8)) u8 (
        .CLOCK_50(clk), .RESET_N(rst_n), .START(start8), .SUB(sub8),
        .A(a8), .B(b8), .CIN(cin8), .BUSY(busy8), .DONE(done8),
        .SUM(sum8), .COUT(cout8), .OVF(ovf8)
    );

    serial_addsub #(.WIDTH(4)) u4 (
        .CLOCK_50(clk), .RESET_N(rst_n), .START(start4), .SUB(sub4),
        .A(a4), .B(b4), .CIN(cin4), .BUSY(busy4), .DONE(done4),
        .SUM(sum4), .COUT(cout4), .OVF(ovf4)
    );

    // Reference: plain modular arithmetic with sign-based overflow rules.
    function automatic void model(input int w, input logic sub, input logic [31:0] a,
                                  input logic [31:0] b, input logic cin,
                                  output logic [31:0] s, output logic co, output logic ov);
        longint unsigned mask, bb, full;
        logic as, bs, ss;
        mask = (64'd1 << w) - 64'd1;
        bb   = sub ? ((longint'(b) & mask) ^ mask) : (longint'(b) & mask);
        full = (longint'(a) & mask) + bb + (sub ? 64'd1 : 64'(cin));
        s    = 32'(full & mask);
        co   = ((full >> w) & 64'd1) != 0;
        as   = a[w-1];
        bs   = b[w-1];
        ss   = s[w-1];
        ov   = sub ? (as != bs && ss != as) : (as == bs && ss != as);
    endfunction

    // Drives one 8-bit operation and observes it; inputs are scrambled while busy.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic sub,
                         input logic cin, input bit poke,
                         output int lat, output int busyc, output int dones,
                         output logic [7:0] s, output logic co, output logic ov,
                         output logic [7:0] mid, output bit tmo);
        int edges;
        @(negedge clk);
        a8 = a; b8 = b; sub8 = sub; cin8 = cin; start8 = 1'b1;
        edges = 0; lat = 0; busyc = 0; dones = 0; tmo = 1'b1;
        s = '0; co = 1'b0; ov = 1'b0; mid = '0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (i == 0) begin
                start8 = 1'b0;
                a8 = 8'($urandom); b8 = 8'($urandom);
                sub8 = 1'($urandom); cin8 = 1'($urandom);
            end
            if (poke && i == 3) begin
                start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
            end
            if (poke && i == 4) start8 = 1'b0;
            if (i == 2) mid = sum8;
            if (busy8) busyc++;
            if (done8) begin
                dones++;
                if (lat == 0) begin
                    lat = edges; s = sum8; co = cout8; ov = ovf8;
                end
            end
            if (lat != 0 && edges >= lat + 3) begin
                tmo = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        int waited;
        rst_n = 1'b0; start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; sub8 = 1'b0; cin8 = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; sub4 = 1'b0; cin4 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy8); end
        total++; if (done8 !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done8); end
        total++; if (sum8 !== 8'h00) begin bad++; $display("FAIL reset_sum got=%h exp=00", sum8); end
        total++; if (cout8 !== 1'b0) begin bad++; $display("FAIL reset_cout got=%b exp=0", cout8); end
        total++; if (ovf8 !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf8); end
        total++; if (sum4 !== 4'h0 || busy4 !== 1'b0) begin
            bad++; $display("FAIL reset_w4 got sum=%h busy=%b exp sum=0 busy=0", sum4, busy4);
        end
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        total++; if (busy8 !== 1'b1) begin bad++; $display("FAIL start_after_reset busy got=%b exp=1", busy8); end
        waited = 0;
        while (!done8 && waited < 20) begin
            @(posedge clk); @(negedge clk); waited++;
        end
        total++; if (!done8 || sum8 !== 8'h46) begin
            bad++; $display("FAIL start_after_reset_sum done=%b got=%h exp=46", done8, sum8);
        end
        last8 = 8'h46;
        @(negedge clk);
    endtask

    task automatic test_directed;
        logic [7:0] av[3] = '{8'h5A, 8'hFF, 8'h80};
        logic [7:0] bv[3] = '{8'h3C, 8'h01, 8'h01};
        logic       sv[3] = '{1'b0, 1'b0, 1'b1};
        logic       cv[3] = '{1'b0, 1'b1, 1'b0};
        logic [7:0] es[3] = '{8'h96, 8'h01, 8'h7F};
        logic       ec[3] = '{1'b0, 1'b1, 1'b1};
        logic       eo[3] = '{1'b1, 1'b0, 1'b1};
        int lat, busyc, dones;
        logic [7:0] s, mid;
        logic co, ov;
        bit tmo;
        for (int i = 0; i < 3; i++) begin
            do_op(av[i], bv[i], sv[i], cv[i], 1'b0, lat, busyc, dones, s, co, ov, mid, tmo);
            total++; if (tmo) begin bad++; $display("FAIL dir%0d_timeout no DONE within budget", i); end
            total++; if (lat != 9) begin bad++; $display("FAIL dir%0d_latency got=%0d exp=9", i, lat); end
            total++; if (busyc != 9) begin bad++; $display("FAIL dir%0d_busy_cycles got=%0d exp=9", i, busyc); end
            total++; if (dones != 1) begin bad++; $display("FAIL dir%0d_done_count got=%0d exp=1", i, dones); end
            total++; if (s !== es[i] || co !== ec[i] || ov !== eo[i]) begin
                bad++; $display("FAIL dir%0d_result got sum=%h cout=%b ovf=%b exp sum=%h cout=%b ovf=%b",
                                i, s, co, ov, es[i], ec[i], eo[i]);
            end
            total++; if (mid !== last8) begin bad++; $display("FAIL dir%0d_hold got=%h exp=%h", i, mid, last8); end
            last8 = es[i];
        end
    endtask

    task automatic test_ignore_start;
        int lat, busyc, dones;
        logic [7:0] s, mid;
        logic co, ov;
        bit tmo;
        do_op(8'h10, 8'h20, 1'b1, 1'b0, 1'b1, lat, busyc, dones, s, co, ov, mid, tmo);
        total++; if (tmo) begin bad++; $display("FAIL ignore_timeout no DONE within budget"); end
        total++; if (dones != 1) begin bad++; $display("FAIL ignore_done_count got=%0d exp=1", dones); end
        total++; if (busyc != 9) begin bad++; $display("FAIL ignore_busy_cycles got=%0d exp=9", busyc); end
        total++; if (s !== 8'hF0 || co !== 1'b0 || ov !== 1'b0) begin
            bad++; $display("FAIL ignore_result got sum=%h cout=%b ovf=%b exp sum=f0 cout=0 ovf=0", s, co, ov);
        end
        last8 = 8'hF0;
    endtask

    task automatic test_random;
        int lat, busyc, dones;
        logic [7:0] s, mid, a, b;
        logic co, ov, sub, cin, eco, eov;
        logic [31:0] es;
        bit tmo;
        for (int n = 0; n < 20; n++) begin
            a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom); cin = 1'($urandom);
            model(8, sub, {24'd0, a}, {24'd0, b}, cin, es, eco, eov);
            do_op(a, b, sub, cin, 1'b0, lat, busyc, dones, s, co, ov, mid, tmo);
            total++; if (tmo || lat != 9 || dones != 1) begin
                bad++; $display("FAIL rand%0d_timing timeout=%0d lat=%0d dones=%0d exp lat=9 dones=1", n, tmo, lat, dones);
            end
            total++; if (s !== es[7:0] || co !== eco || ov !== eov) begin
                bad++; $display("FAIL rand%0d_result a=%h b=%h sub=%b cin=%b got sum=%h cout=%b ovf=%b exp sum=%h cout=%b ovf=%b",
                                n, a, b, sub, cin, s, co, ov, es[7:0], eco, eov);
            end
            total++; if (mid !== last8) begin bad++; $display("FAIL rand%0d_hold got=%h exp=%h", n, mid, last8); end
            last8 = es[7:0];
        end
    endtask

    task automatic test_reset_abort;
        int dones, lat, busyc;
        logic [7:0] s, mid;
        logic co, ov;
        bit tmo;
        @(negedge clk);
        a8 = 8'h0F; b8 = 8'h01; sub8 = 1'b0; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        total++; if (busy8 !== 1'b0 || done8 !== 1'b0) begin
            bad++; $display("FAIL abort_state got busy=%b done=%b exp busy=0 done=0", busy8, done8);
        end
        total++; if (sum8 !== 8'h00 || cout8 !== 1'b0 || ovf8 !== 1'b0) begin
            bad++; $display("FAIL abort_outputs got sum=%h cout=%b ovf=%b exp 00/0/0", sum8, cout8, ovf8);
        end
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); @(negedge clk);
            if (done8) dones++;
        end
        total++; if (dones != 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", dones); end
        last8 = 8'h00;
        do_op(8'h03, 8'h04, 1'b0, 1'b0, 1'b0, lat, busyc, dones, s, co, ov, mid, tmo);
        total++; if (tmo || lat != 9 || s !== 8'h07 || co !== 1'b0 || ov !== 1'b0) begin
            bad++; $display("FAIL abort_followup timeout=%0d lat=%0d got sum=%h cout=%b ovf=%b exp lat=9 sum=07 cout=0 ovf=0",
                            tmo, lat, s, co, ov);
        end
        last8 = 8'h07;
    endtask

    task automatic test_width4;
        logic [3:0] av, bv;
        logic sv, cv, eco, eov;
        logic [31:0] es;
        int lat;
        for (int n = 0; n < 8; n++) begin
            if (n == 0) begin av = 4'hF; bv = 4'h1; sv = 1'b0; cv = 1'b0; end
            else begin av = 4'($urandom); bv = 4'($urandom); sv = 1'($urandom); cv = 1'($urandom); end
            model(4, sv, {28'd0, av}, {28'd0, bv}, cv, es, eco, eov);
            @(negedge clk);
            a4 = av; b4 = bv; sub4 = sv; cin4 = cv; start4 = 1'b1;
            lat = 0;
            for (int e = 1; e <= 15; e++) begin
                @(posedge clk); @(negedge clk);
                start4 = 1'b0;
                if (done4) begin lat = e; break; end
            end
            total++; if (lat != 5) begin bad++; $display("FAIL w4_%0d_latency got=%0d exp=5", n, lat); end
            total++; if (sum4 !== es[3:0] || cout4 !== eco || ovf4 !== eov) begin
                bad++; $display("FAIL w4_%0d_result a=%h b=%h sub=%b cin=%b got sum=%h cout=%b ovf=%b exp sum=%h cout=%b ovf=%b",
                                n, av, bv, sv, cv, sum4, cout4, ovf4, es[3:0], eco, eov);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_random();
        test_reset_abort();
        test_width4();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
